instr_ram_arbiter: RTL and testbench
====================================

INSTR_RAM_ARBITER -- requirements
Module: instr_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word address width of the instruction RAM.
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, meaning consecutive loader denials tolerated before a forced loader grant; legal range 1..255.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have fetch-port ports: f_req in 1; f_addr in ADDR_W; f_gnt out 1; f_rvalid out 1; f_rdata out DATA_W; f_rready in 1.
REQ-007 SHALL have loader-port ports: l_req in 1; l_we in 1; l_addr in ADDR_W; l_wdata in DATA_W; l_gnt out 1; l_rvalid out 1; l_rdata out DATA_W; boot_done in 1; boot_enter in 1; in_boot out 1.
REQ-008 SHALL have RAM-side ports: ram_ce out 1; ram_oce out 1; ram_wre out 1; ram_ad out ADDR_W; ram_din out DATA_W; ram_dout in DATA_W. The RAM is single-port, bypass read, data valid the cycle after ce.

Function
REQ-009 SHALL implement FSM states BOOT, RUN, DRAIN.
REQ-010 BOOT: l_gnt = l_req, f_gnt = 0; boot_done high -> RUN next cycle.
REQ-011 RUN: fetch has priority; l_gnt = l_req && !f_gnt, except forced grant (REQ-013); boot_enter high -> DRAIN, with no grants issued in that cycle.
REQ-012 DRAIN: no grants; lasts exactly one cycle so any in-flight read returns; then -> BOOT.
REQ-013 Starvation counter (8 bit) SHALL increment each RUN cycle with l_req=1 and l_gnt=0; when it equals STARVE_MAX, l_gnt=1 and f_gnt=0 that cycle; counter clears on any l_gnt or when l_req=0.
REQ-014 boot_done and boot_enter high together SHALL be resolved in favour of boot_enter in RUN and boot_done in BOOT; both are ignored in DRAIN.
REQ-015 ram_ce = f_gnt | l_gnt; ram_wre = l_gnt & l_we; ram_ad/ram_din muxed from granted port (don't-care zeros when idle); ram_oce held 1.
REQ-016 A one-bit owner tag SHALL be registered on every read grant; the cycle after, l_rvalid (loader tag) or fetch return (fetch tag) asserts with data = ram_dout.
REQ-017 Loader writes SHALL produce no l_rvalid; write completes in the grant cycle.
REQ-018 l_rdata SHALL be combinationally ram_dout; l_rvalid is a single-cycle pulse.
REQ-019 in_boot SHALL equal (state == BOOT).

Reset
REQ-020 Asynchronous assertion SHALL force state BOOT, starvation counter 0, owner tag/pending flags 0, all valid outputs 0, buffer 0.
REQ-021 Reset asserted mid-read SHALL discard the pending return; no rvalid after deassertion without a new grant.
REQ-022 Grants SHALL be combinational from registered state, so during reset f_gnt=0, l_gnt=0, ram_ce=0, ram_wre=0.

Configuration
REQ-023 Macro IRAM_ARB_FETCH_BUF_EN SHALL select fetch return mode.
REQ-024 Without it: f_rvalid is a one-cycle pulse the cycle after f_gnt, f_rdata = ram_dout, f_rready ignored, back-to-back fetch grants every cycle.
REQ-025 With it: fetch return is captured into a DATA_W register; f_rvalid asserts two cycles after f_gnt and holds, with f_rdata stable, until f_rready=1; f_gnt is blocked while the buffer is valid or a fetch read is in flight, so throughput is at most one fetch per 3 cycles.
REQ-026 With it, DRAIN SHALL also wait until the buffer is empty before entering BOOT.

Verification
REQ-027 After reset: l_req=1, l_we=1, addr 0x005, wdata 0xDEADBEEF -> l_gnt=1, ram_wre=1; then a read of 0x005 -> l_rvalid next cycle, l_rdata=0xDEADBEEF; f_req=1 is never granted in BOOT.
REQ-028 Pulse boot_done, then hold f_req=1 continuously at incrementing addresses -> f_gnt every cycle, f_rvalid one cycle later each (macro off).
REQ-029 In RUN, hold f_req=1 and l_req=1 with STARVE_MAX=8 -> 8 fetch grants, then 1 loader grant, repeating; the loader is never denied 9 consecutive cycles.
REQ-030 Pulse boot_enter in RUN with a fetch read granted the prior cycle -> f_rvalid still delivered; one DRAIN cycle; in_boot=1 the next cycle.
REQ-031 Macro on: f_rready=0 for 5 cycles after a fetch -> f_rvalid and f_rdata held stable, f_gnt=0; f_rready=1 -> buffer clears and the next f_gnt is allowed the following cycle.
REQ-032 Assert reset during a loader read grant -> no l_rvalid after reset release; state BOOT.

Source files
------------

// File: rtl/instr_ram_arbiter.sv
// Arbitrates a single-port instruction RAM between a CPU fetch port and a boot loader port.
// Define IRAM_ARB_FETCH_BUF_EN to hold fetch returns in a buffer until f_rready.
module instr_ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              f_rready,
    // loader port
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    input  logic              boot_done,
    input  logic              boot_enter,
    output logic              in_boot,
    // RAM side
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [7:0] starve_q, starve_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;   // 1 = loader, 0 = fetch
    logic       fetch_ret;
    logic       fetch_ok;
    logic       drain_done;

    assign fetch_ret = rd_pend_q & ~rd_owner_q;

`ifdef IRAM_ARB_FETCH_BUF_EN
    logic              fbuf_valid_q, fbuf_valid_d;
    logic [DATA_W-1:0] fbuf_q, fbuf_d;

    always_comb begin
        fbuf_valid_d = fbuf_valid_q;
        fbuf_d       = fbuf_q;
        if (fbuf_valid_q && f_rready) begin
            fbuf_valid_d = 1'b0;
        end
        if (fetch_ret) begin
            fbuf_valid_d = 1'b1;
            fbuf_d       = ram_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fbuf_valid_q <= 1'b0;
            fbuf_q       <= '0;
        end else begin
            fbuf_valid_q <= fbuf_valid_d;
            fbuf_q       <= fbuf_d;
        end
    end

    // One fetch outstanding end to end: nothing in flight and the buffer drained.
    assign fetch_ok   = ~fbuf_valid_q & ~fetch_ret;
    assign drain_done = ~fbuf_valid_d;
    assign f_rvalid   = fbuf_valid_q;
    assign f_rdata    = fbuf_q;
`else
    logic unused_f_rready;

    assign unused_f_rready = f_rready;
    assign fetch_ok        = 1'b1;
    assign drain_done      = 1'b1;
    assign f_rvalid        = fetch_ret;
    assign f_rdata         = ram_dout;
`endif

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        case (state_q)
            BOOT: begin
                l_gnt = l_req;
                if (boot_done) state_d = RUN;
            end
            RUN: begin
                if (boot_enter) begin
                    state_d = DRAIN;
                end else if (l_req && starve_q == STARVE_LIM) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = f_req & fetch_ok;
                    l_gnt = l_req & ~f_gnt;
                end
            end
            DRAIN: begin
                if (drain_done) state_d = BOOT;
            end
            default: state_d = BOOT;
        endcase
        // Grants must stay quiet while reset is held, not just after the first edge.
        if (reset) begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (l_gnt || !l_req) begin
            starve_d = '0;
        end else if (state_q == RUN && starve_q != 8'hFF) begin
            starve_d = starve_q + 8'd1;
        end
        rd_pend_d  = f_gnt | (l_gnt & ~l_we);
        rd_owner_d = rd_pend_d ? l_gnt : rd_owner_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            starve_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        ram_ad = '0;
        if (f_gnt) begin
            ram_ad = f_addr;
        end else if (l_gnt) begin
            ram_ad = l_addr;
        end
    end

    assign ram_ce   = f_gnt | l_gnt;
    assign ram_wre  = l_gnt & l_we;
    assign ram_din  = l_gnt ? l_wdata : '0;
    assign ram_oce  = 1'b1;
    assign l_rvalid = rd_pend_q & rd_owner_q;
    assign l_rdata  = ram_dout;
    assign in_boot  = (state_q == BOOT);

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed self-checking bench for instr_ram_arbiter with a behavioural single-port RAM.
// Boot/loader vectors are table driven; fetch streaming, starvation, drain and reset are hand sequences.
module tb_instr_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req, f_gnt, f_rvalid, f_rready;
    logic [11:0] f_addr;
    logic [31:0] f_rdata;
    logic        l_req, l_we, l_gnt, l_rvalid;
    logic [11:0] l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic        boot_done, boot_enter, in_boot;
    logic        ram_ce, ram_oce, ram_wre;
    logic [11:0] ram_ad;
    logic [31:0] ram_din, ram_dout;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        f_req;
        logic [11:0] f_addr;
        logic        l_req;
        logic        l_we;
        logic [11:0] l_addr;
        logic [31:0] l_wdata;
        logic        boot_done;
        logic        boot_enter;
        logic        f_rready;
    } in_t;

    typedef struct {
        in_t         in;
        logic        f_gnt;
        logic        l_gnt;
        logic        ram_wre;
        logic        f_rvalid;
        logic        l_rvalid;
        logic [31:0] l_rdata;
        logic        in_boot;
    } vec_t;

    instr_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_rready(f_rready),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .boot_done(boot_done), .boot_enter(boot_enter), .in_boot(in_boot),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [11:0] a);
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    // Behavioural RAM: read data appears the cycle after ce.
    logic [31:0] mem [4096];
    initial for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout    <= mem[ram_ad];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic in_t mk(input logic fr, input logic [11:0] fa, input logic lr,
                               input logic lw, input logic [11:0] la, input logic [31:0] wd,
                               input logic bd, input logic be, input logic rr);
        in_t v;
        v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_we = lw; v.l_addr = la;
        v.l_wdata = wd; v.boot_done = bd; v.boot_enter = be; v.f_rready = rr;
        return v;
    endfunction

    task automatic drive(input in_t v);
        f_req = v.f_req; f_addr = v.f_addr; l_req = v.l_req; l_we = v.l_we;
        l_addr = v.l_addr; l_wdata = v.l_wdata; boot_done = v.boot_done;
        boot_enter = v.boot_enter; f_rready = v.f_rready;
    endtask

    task automatic apply(input in_t v);
        @(negedge clk);
        drive(v);
        #1;
    endtask

    localparam int NV = 9;
    vec_t tbl [NV];
    in_t  idle;
    in_t  s;

    initial begin
        idle = mk(0, 12'h0, 0, 0, 12'h0, 32'h0, 0, 0, 0);
        //              f_req f_addr  l_req we l_addr  wdata         bd be rr   fg lg wre frv lrv l_rdata       inb
        tbl[0] = '{mk(0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 0), 0, 0, 0, 0, 0, 32'h0,        1};
        tbl[1] = '{mk(1, 12'h010, 1, 1, 12'h005, 32'hDEADBEEF, 0, 0, 0), 0, 1, 1, 0, 0, 32'h0,        1};
        tbl[2] = '{mk(1, 12'h010, 1, 0, 12'h005, 32'h0,        0, 0, 0), 0, 1, 0, 0, 0, 32'h0,        1};
        tbl[3] = '{mk(1, 12'h010, 0, 0, 12'h000, 32'h0,        0, 0, 0), 0, 0, 0, 0, 1, 32'hDEADBEEF, 1};
        tbl[4] = '{mk(1, 12'h010, 0, 0, 12'h000, 32'h0,        1, 1, 0), 0, 0, 0, 0, 0, 32'h0,        1};
        tbl[5] = '{mk(1, 12'h020, 1, 0, 12'h007, 32'h0,        1, 1, 0), 0, 0, 0, 0, 0, 32'h0,        0};
        tbl[6] = '{mk(1, 12'h020, 1, 0, 12'h007, 32'h0,        1, 1, 0), 0, 0, 0, 0, 0, 32'h0,        0};
        tbl[7] = '{mk(1, 12'h020, 0, 0, 12'h000, 32'h0,        1, 0, 0), 0, 0, 0, 0, 0, 32'h0,        1};
        tbl[8] = '{mk(0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 0), 0, 0, 0, 0, 0, 32'h0,        0};

        // Reset state with every request asserted.
        reset = 1'b1;
        drive(mk(1, 12'h001, 1, 1, 12'h002, 32'hFFFF_FFFF, 1, 1, 1));
        #3;
        check("rst_f_gnt", f_gnt, 0);
        check("rst_l_gnt", l_gnt, 0);
        check("rst_ram_ce", ram_ce, 0);
        check("rst_ram_wre", ram_wre, 0);
        check("rst_ram_oce", ram_oce, 1);
        check("rst_in_boot", in_boot, 1);
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_l_rvalid", l_rvalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(idle);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].in);
            check($sformatf("t%0d_f_gnt", i), f_gnt, tbl[i].f_gnt);
            check($sformatf("t%0d_l_gnt", i), l_gnt, tbl[i].l_gnt);
            check($sformatf("t%0d_ram_ce", i), ram_ce, tbl[i].f_gnt | tbl[i].l_gnt);
            check($sformatf("t%0d_ram_wre", i), ram_wre, tbl[i].ram_wre);
            check($sformatf("t%0d_f_rvalid", i), f_rvalid, tbl[i].f_rvalid);
            check($sformatf("t%0d_l_rvalid", i), l_rvalid, tbl[i].l_rvalid);
            check($sformatf("t%0d_in_boot", i), in_boot, tbl[i].in_boot);
            if (tbl[i].l_rvalid) check($sformatf("t%0d_l_rdata", i), l_rdata, tbl[i].l_rdata);
        end

`ifndef IRAM_ARB_FETCH_BUF_EN
        // Back-to-back fetch stream.
        for (int i = 0; i < 6; i++) begin
            s = idle; s.f_req = 1; s.f_addr = 12'h100 + 12'(i);
            apply(s);
            check($sformatf("stream%0d_f_gnt", i), f_gnt, 1);
            check($sformatf("stream%0d_ram_ad", i), ram_ad, 12'h100 + 12'(i));
            check($sformatf("stream%0d_f_rvalid", i), f_rvalid, (i > 0));
            if (i > 0) check($sformatf("stream%0d_f_rdata", i), f_rdata, pat(12'h100 + 12'(i - 1)));
        end
        // boot_enter right after a fetch grant: data still returns, one DRAIN cycle.
        s = idle; s.boot_enter = 1;
        apply(s);
        check("enter_f_gnt", f_gnt, 0);
        check("enter_f_rvalid", f_rvalid, 1);
        check("enter_f_rdata", f_rdata, pat(12'h105));
        check("enter_in_boot", in_boot, 0);
        apply(idle);
        check("drain_f_rvalid", f_rvalid, 0);
        check("drain_in_boot", in_boot, 0);
        s = idle; s.boot_done = 1;
        apply(s);
        check("reboot_in_boot", in_boot, 1);

        // Starvation: 8 fetch grants then one forced loader grant, repeating.
        begin
            int run = 0;
            int max_run = 0;
            for (int i = 0; i < 27; i++) begin
                s = idle; s.f_req = 1; s.f_addr = 12'h200 + 12'(i); s.l_req = 1; s.l_addr = 12'h300;
                apply(s);
                check($sformatf("starve%0d_l_gnt", i), l_gnt, (i % 9 == 8));
                check($sformatf("starve%0d_f_gnt", i), f_gnt, (i % 9 != 8));
                if (i > 0) begin
                    if ((i - 1) % 9 == 8) begin
                        check($sformatf("starve%0d_l_rvalid", i), l_rvalid, 1);
                        check($sformatf("starve%0d_l_rdata", i), l_rdata, pat(12'h300));
                        check($sformatf("starve%0d_f_rvalid", i), f_rvalid, 0);
                    end else begin
                        check($sformatf("starve%0d_f_rvalid", i), f_rvalid, 1);
                        check($sformatf("starve%0d_f_rdata", i), f_rdata, pat(12'h200 + 12'(i - 1)));
                        check($sformatf("starve%0d_l_rvalid", i), l_rvalid, 0);
                    end
                end
                run = l_gnt ? 0 : run + 1;
                if (run > max_run) max_run = run;
            end
            check("starve_max_denials_le_8", (max_run <= 8), 1);
        end
        apply(idle);
        check("starve_tail_l_rvalid", l_rvalid, 1);
        check("starve_tail_l_rdata", l_rdata, pat(12'h300));
        check("starve_tail_f_rvalid", f_rvalid, 0);
`else
        // Buffered fetch return held until f_rready.
        s = idle; s.f_req = 1; s.f_addr = 12'h150;
        apply(s);
        check("buf_c0_f_gnt", f_gnt, 1);
        apply(s);
        check("buf_c1_f_gnt", f_gnt, 0);
        check("buf_c1_f_rvalid", f_rvalid, 0);
        for (int i = 0; i < 5; i++) begin
            apply(s);
            check($sformatf("buf_hold%0d_f_rvalid", i), f_rvalid, 1);
            check($sformatf("buf_hold%0d_f_rdata", i), f_rdata, pat(12'h150));
            check($sformatf("buf_hold%0d_f_gnt", i), f_gnt, 0);
        end
        s.f_rready = 1;
        apply(s);
        check("buf_rdy_f_rvalid", f_rvalid, 1);
        check("buf_rdy_f_gnt", f_gnt, 0);
        s.f_addr = 12'h151;
        apply(s);
        check("buf_next_f_gnt", f_gnt, 1);
        check("buf_next_f_rvalid", f_rvalid, 0);
        apply(s);
        check("buf_next2_f_gnt", f_gnt, 0);
        // Enter DRAIN with a full buffer; DRAIN waits for it to empty.
        s = idle; s.boot_enter = 1;
        apply(s);
        check("buf_enter_f_rvalid", f_rvalid, 1);
        check("buf_enter_f_rdata", f_rdata, pat(12'h151));
        apply(idle);
        check("buf_drain1_in_boot", in_boot, 0);
        check("buf_drain1_f_rvalid", f_rvalid, 1);
        s = idle; s.f_rready = 1;
        apply(s);
        check("buf_drain2_in_boot", in_boot, 0);
        apply(idle);
        check("buf_boot_in_boot", in_boot, 1);
        check("buf_boot_f_rvalid", f_rvalid, 0);
        s = idle; s.boot_done = 1;
        apply(s);
`endif

        // Reset during a loader read grant discards the return.
        s = idle; s.l_req = 1; s.l_addr = 12'h005;
        apply(s);
        check("rstmid_l_gnt", l_gnt, 1);
        check("rstmid_in_boot", in_boot, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rstmid_l_rvalid", l_rvalid, 0);
        check("rstmid_l_gnt_held", l_gnt, 0);
        check("rstmid_ram_ce", ram_ce, 0);
        check("rstmid_in_boot_rst", in_boot, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        #1;
        check("rstrel_l_rvalid", l_rvalid, 0);
        check("rstrel_in_boot", in_boot, 1);
        apply(idle);
        check("rstrel2_l_rvalid", l_rvalid, 0);
        check("rstrel2_f_rvalid", f_rvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
